// File: rtl/ram_dumper_if.sv
// Line-wide RAM read port between the UART readback engine (master) and the cache-line RAM (slave).
// Read data is registered by the RAM and becomes valid the cycle after mem_rd_en.
interface ram_dumper_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata
  );
endinterface

// File: rtl/ram_dumper.sv
// UART readback engine: reads a run of 32-bit words from the cache-line RAM and sends
// each word LSB byte first as back-to-back 8N1 frames on uart_tx_o.
module ram_dumper #(
  parameter int CLK_FREQ         = 50_000_000,
  parameter int BAUD_RATE        = 115200,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int RAM_DEPTH        = 32768
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [$clog2(RAM_DEPTH)-1:0] start_addr_i,
  input  logic [15:0]                  word_count_i,
  output logic                         busy_o,
  output logic                         done_o,
  ram_dumper_if.master                 mem,
  output logic                         uart_tx_o
);

  localparam int ADDR_W         = $clog2(RAM_DEPTH);
  localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W         = $clog2(CLKS_PER_BIT);
  localparam int WORDS_PER_LINE = CACHE_LINE_WIDTH / 32;
  localparam int LINE_ADDR_BITS = $clog2(WORDS_PER_LINE);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_CAP  = 3'd2,
    TX_BYTE = 3'd3,
    NEXT    = 3'd4,
    FINISH  = 3'd5
  } state_e;

  state_e                      state_r, state_nxt_s;
  logic [ADDR_W-1:0]           addr_r, addr_nxt_s, addr_inc_s;
  logic [15:0]                 remain_r, remain_nxt_s;
  logic [CACHE_LINE_WIDTH-1:0] line_r, line_nxt_s;
  logic [31:0]                 word_r, word_nxt_s;
  logic [1:0]                  byte_idx_r, byte_idx_nxt_s;
  logic [3:0]                  bit_idx_r, bit_idx_nxt_s;
  logic [BAUD_W-1:0]           baud_cnt_r, baud_cnt_nxt_s;
  logic                        tx_r, tx_nxt_s;
  logic                        busy_r, busy_nxt_s;
  logic                        done_r, done_nxt_s;
  logic                        rd_en_r, rd_en_nxt_s;

  function automatic logic [31:0] select_word(input logic [CACHE_LINE_WIDTH-1:0] line,
                                              input logic [LINE_ADDR_BITS-1:0]   off);
    return line[{off, 5'd0} +: 32];
  endfunction

  // Bit 0 is the start bit, 1..8 carry data LSB first, 9 is the stop bit.
  function automatic logic frame_bit(input logic [31:0] word,
                                     input logic [1:0]  byte_idx,
                                     input logic [3:0]  bit_idx);
    logic [7:0] data_v;
    data_v = word[{byte_idx, 3'd0} +: 8];
    if (bit_idx == 4'd0) begin
      return 1'b0;
    end else if (bit_idx == 4'd9) begin
      return 1'b1;
    end else begin
      return data_v[bit_idx[2:0] - 3'd1];
    end
  endfunction

  assign addr_inc_s = addr_r + ADDR_W'(1);

  // Next-state, datapath and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt_s    = state_r;
    addr_nxt_s     = addr_r;
    remain_nxt_s   = remain_r;
    line_nxt_s     = line_r;
    word_nxt_s     = word_r;
    byte_idx_nxt_s = byte_idx_r;
    bit_idx_nxt_s  = bit_idx_r;
    baud_cnt_nxt_s = baud_cnt_r;

    case (state_r)
      IDLE: begin
        if (start_i) begin
          if (word_count_i != 16'd0) begin
            addr_nxt_s   = start_addr_i;
            remain_nxt_s = word_count_i;
            state_nxt_s  = RD_REQ;
          end else begin
            state_nxt_s  = FINISH;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_REQ: begin
        state_nxt_s = RD_CAP;
      end
      RD_CAP: begin
        line_nxt_s     = mem.mem_rdata;
        word_nxt_s     = select_word(mem.mem_rdata, addr_r[LINE_ADDR_BITS-1:0]);
        byte_idx_nxt_s = 2'd0;
        bit_idx_nxt_s  = 4'd0;
        baud_cnt_nxt_s = '0;
        state_nxt_s    = TX_BYTE;
      end
      TX_BYTE: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_nxt_s = '0;
          if (bit_idx_r == 4'd9) begin
            bit_idx_nxt_s = 4'd0;
            if (byte_idx_r == 2'd3) begin
              state_nxt_s = NEXT;
            end else begin
              byte_idx_nxt_s = byte_idx_r + 2'd1;
            end
          end else begin
            bit_idx_nxt_s = bit_idx_r + 4'd1;
          end
        end else begin
          baud_cnt_nxt_s = baud_cnt_r + BAUD_W'(1);
        end
      end
      NEXT: begin
        remain_nxt_s = remain_r - 16'd1;
        addr_nxt_s   = addr_inc_s;
        if (remain_r == 16'd1) begin
          state_nxt_s = FINISH;
        end else if (addr_inc_s[LINE_ADDR_BITS-1:0] == LINE_ADDR_BITS'(0)) begin
          state_nxt_s = RD_REQ;
        end else begin
          // Next word is already in the buffered line; no RAM access.
          word_nxt_s     = select_word(line_r, addr_inc_s[LINE_ADDR_BITS-1:0]);
          byte_idx_nxt_s = 2'd0;
          bit_idx_nxt_s  = 4'd0;
          baud_cnt_nxt_s = '0;
          state_nxt_s    = TX_BYTE;
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    busy_nxt_s  = (state_nxt_s != IDLE);
    done_nxt_s  = (state_r == FINISH);
    rd_en_nxt_s = (state_nxt_s == RD_REQ);
    if (state_nxt_s == TX_BYTE) begin
      tx_nxt_s = frame_bit(word_nxt_s, byte_idx_nxt_s, bit_idx_nxt_s);
    end else begin
      tx_nxt_s = 1'b1;
    end
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      remain_r   <= 16'd0;
      line_r     <= '0;
      word_r     <= 32'd0;
      byte_idx_r <= 2'd0;
      bit_idx_r  <= 4'd0;
      baud_cnt_r <= '0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_en_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      addr_r     <= addr_nxt_s;
      remain_r   <= remain_nxt_s;
      line_r     <= line_nxt_s;
      word_r     <= word_nxt_s;
      byte_idx_r <= byte_idx_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      baud_cnt_r <= baud_cnt_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      rd_en_r    <= rd_en_nxt_s;
    end
  end

  assign uart_tx_o     = tx_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_rd_en = rd_en_r;

endmodule

// File: tb/tb_ram_dumper.sv
// Directed bench for ram_dumper at 4 clocks per UART bit: RAM model, exact-timing 8N1 receiver,
// vector table of dumps plus hand-written mid-dump start and mid-frame reset sequences.
module tb_ram_dumper;

  localparam int AW  = 15;
  localparam int CLW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [15:0]   word_count;
  logic          busy;
  logic          done;
  logic          tx;

  ram_dumper_if #(.ADDR_W(AW), .DATA_W(CLW)) bus ();

  ram_dumper #(
    .CLK_FREQ(460800), .BAUD_RATE(115200), .CACHE_LINE_WIDTH(CLW), .RAM_DEPTH(32768)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr),
    .word_count_i(word_count), .busy_o(busy), .done_o(done), .mem(bus), .uart_tx_o(tx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
    if (a == 15'h0010) return 32'hDEADBEEF;
    return (32'h9E3779B9 * {17'd0, a}) + 32'h0BADF00D;
  endfunction

  // RAM model: registered line read, valid the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata <= {ram_word({bus.mem_addr[14:2], 2'd3}), ram_word({bus.mem_addr[14:2], 2'd2}),
                        ram_word({bus.mem_addr[14:2], 2'd1}), ram_word({bus.mem_addr[14:2], 2'd0})};
    end
  end

  logic [AW-1:0] rd_q[$];
  logic [7:0]    rx_q[$];
  int            done_cnt  = 0;
  int            frame_err = 0;
  logic          rx_active = 1'b0;
  logic [5:0]    rx_cnt    = 6'd0;
  logic [39:0]   rx_bits   = 40'd0;

  // Returns {ok, byte}; every bit must hold for exactly four samples.
  function automatic logic [8:0] decode_frame(input logic [39:0] f);
    logic [3:0] grp;
    logic [9:0] bits;
    logic       ok;
    ok   = 1'b1;
    bits = 10'd0;
    for (int b = 0; b < 10; b++) begin
      grp = 4'(f >> (4 * b));
      if (grp != 4'h0 && grp != 4'hF) ok = 1'b0;
      bits = {grp[0], bits[9:1]};
    end
    if (bits[0] != 1'b0 || bits[9] != 1'b1) ok = 1'b0;
    return {ok, bits[8:1]};
  endfunction

  // Monitor sampled on the falling edge: reads, done pulses and received bytes.
  always @(negedge clk) begin
    logic [8:0] res;
    if (rst) begin
      rx_active = 1'b0;
      rx_cnt    = 6'd0;
    end else begin
      if (bus.mem_rd_en) rd_q.push_back(bus.mem_addr);
      if (done) done_cnt++;
      if (rx_active || !tx) begin
        rx_active = 1'b1;
        rx_bits   = {tx, rx_bits[39:1]};
        rx_cnt    = rx_cnt + 6'd1;
        if (rx_cnt == 6'd40) begin
          res = decode_frame(rx_bits);
          if (res[8]) rx_q.push_back(res[7:0]);
          else frame_err++;
          rx_active = 1'b0;
          rx_cnt    = 6'd0;
        end
      end
    end
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  int   rd_base, rx_base, done_base, err_base;
  logic busy_k1, tx_k3, busy_at_done;
  logic [AW-1:0] addr_k1;

  // Issue one start at cycle T; optionally pulse a second start (other args) at T+inj.
  task automatic run_dump(input logic [AW-1:0] a, input logic [15:0] n, input int inj, output int kd);
    rd_base   = rd_q.size();
    rx_base   = rx_q.size();
    done_base = done_cnt;
    err_base  = frame_err;
    busy_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1; start_addr = a; word_count = n;
    kd = -1;
    for (int k = 1; k <= 3000 && kd < 0; k++) begin
      @(negedge clk);
      start = (k == inj);
      start_addr = 15'h0100;
      word_count = 16'd2;
      if (k == 1) begin busy_k1 = busy; addr_k1 = bus.mem_addr; end
      if (k == 3) tx_k3 = tx;
      if (done) begin kd = k; busy_at_done = busy; end
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_dump(input logic [AW-1:0] a, input logic [15:0] n,
                            input int exp_reads, input int exp_done, input int kd);
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] wa;
    logic [31:0]   w;
    int            idx;
    chk("done_seen", 32'(kd >= 0), 32'd1);
    chk("done_cycle", kd, exp_done);
    chk("done_pulses", done_cnt - done_base, 32'd1);
    chk("busy_at_done", 32'(busy_at_done), 32'd0);
    for (int i = 0; i < int'(n); i++) begin
      wa = a + 15'(i);
      if (i == 0 || wa[1:0] == 2'b00) exp_q.push_back(wa);
    end
    chk("read_count", rd_q.size() - rd_base, exp_reads);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd_base + i < rd_q.size()) chk("read_addr", 32'(rd_q[rd_base + i]), 32'(exp_q[i]));
    end
    if (n != 16'd0) begin
      chk("busy_t1", 32'(busy_k1), 32'd1);
      chk("addr_t1", 32'(addr_k1), 32'(a));
      chk("tx_start_t3", 32'(tx_k3), 32'd0);
    end
    chk("byte_count", rx_q.size() - rx_base, 4 * int'(n));
    for (int i = 0; i < int'(n); i++) begin
      w = ram_word(a + 15'(i));
      for (int j = 0; j < 4; j++) begin
        idx = rx_base + 4 * i + j;
        if (idx < rx_q.size()) chk("byte", 32'(rx_q[idx]), 32'(8'(w >> (8 * j))));
      end
    end
    chk("frame_err", frame_err - err_base, 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   cnt;
    int            exp_reads;
    int            exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int kd;
    // Done lands 2*reads + 161*words + 2 cycles after the start cycle.
    vecs[0] = '{15'h0010, 16'd1, 1, 165};
    vecs[1] = '{15'h000E, 16'd4, 2, 650};
    vecs[2] = '{15'h7FFF, 16'd2, 2, 328};
    vecs[3] = '{15'h0000, 16'd0, 0, 2};
    vecs[4] = '{15'h0021, 16'd3, 1, 487};

    rst = 1'b1; start = 1'b0; start_addr = 15'h0; word_count = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].addr, vecs[v].cnt, 0, kd);
      check_dump(vecs[v].addr, vecs[v].cnt, vecs[v].exp_reads, vecs[v].exp_done, kd);
    end

    // Second start mid-dump must be ignored.
    run_dump(15'h000E, 16'd4, 50, kd);
    check_dump(15'h000E, 16'd4, 2, 650, kd);

    // Reset during a data bit of the first byte.
    rd_base = rd_q.size(); rx_base = rx_q.size(); done_base = done_cnt; err_base = frame_err;
    @(negedge clk);
    start = 1'b1; start_addr = 15'h0020; word_count = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_no_done", done_cnt - done_base, 32'd0);
    chk("abort_reads", rd_q.size() - rd_base, 32'd1);
    chk("abort_bytes", rx_q.size() - rx_base, 32'd0);
    chk("abort_frame_err", frame_err - err_base, 32'd0);
    chk("abort_tx_idle", 32'(tx), 32'd1);

    run_dump(15'h0010, 16'd1, 0, kd);
    check_dump(15'h0010, 16'd1, 1, 165, kd);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
